// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer driving an external combinational 8-bit ALU.
// Owns the PC, a 4x8 register file and the sticky carry flag; 3 cycles per instruction.
module cpu_sequencer #(
    parameter int          ADDR_W   = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd_en,
    input  logic [15:0]       imem_data,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [2:0]        alu_sel,
    input  logic [7:0]        alu_result,
    input  logic              alu_carry,
    output logic              rf_we,
    output logic [1:0]        rf_widx,
    output logic              carry_flag,
    output logic              busy,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    input  logic [1:0]        dbg_idx,
    output logic [7:0]        dbg_data,
    output logic [2:0]        dbg_state
);

    localparam logic [ADDR_W-1:0] PC0 = ADDR_W'(RESET_PC);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_ir;
    logic [7:0]        r_rf [4];
    logic [7:0]        r_alu_a;
    logic [7:0]        r_alu_b;
    logic [2:0]        r_alu_sel;
    logic              r_rd_en;
    logic              r_rf_we;
    logic              r_carry;
    logic              r_busy;
    logic              r_halted;

    logic [1:0]        w_rd;
    logic [1:0]        w_rs;
    logic              w_unused_bits;

    assign w_rd = imem_data[11:10];
    assign w_rs = imem_data[1:0];
    // Only rd is needed after DECODE; bit 8 of the instruction is reserved.
    assign w_unused_bits = ^{r_ir[15:12], r_ir[9:0], imem_data[8]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_pc      <= PC0;
            r_ir      <= '0;
            for (int i = 0; i < 4; i++) r_rf[i] <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_sel <= '0;
            r_rd_en   <= 1'b0;
            r_rf_we   <= 1'b0;
            r_carry   <= 1'b0;
            r_busy    <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        r_state  <= S_FETCH;
                        r_pc     <= PC0;
                        r_rd_en  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_halted <= 1'b0;
                    end
                end
                S_FETCH: begin
                    r_state <= S_DECODE;
                    r_rd_en <= 1'b0;
                end
                S_DECODE: begin
                    r_ir <= imem_data;
                    if (imem_data[15]) begin
                        r_state  <= S_HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else begin
                        // ALU inputs only ever change on this edge, so they are stable through EXEC.
                        r_alu_a   <= r_rf[w_rd];
                        r_alu_b   <= imem_data[9] ? imem_data[7:0] : r_rf[w_rs];
                        r_alu_sel <= imem_data[14:12];
                        r_rf_we   <= 1'b1;
                        r_state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rf[r_ir[11:10]] <= alu_result;
                    r_carry           <= alu_carry;
                    r_pc              <= r_pc + ADDR_W'(1);
                    r_rf_we           <= 1'b0;
                    r_rd_en           <= 1'b1;
                    r_state           <= S_FETCH;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem_addr  = r_pc;
    assign imem_rd_en = r_rd_en;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_sel    = r_alu_sel;
    assign rf_we      = r_rf_we;
    assign rf_widx    = r_ir[11:10];
    assign carry_flag = r_carry;
    assign busy       = r_busy;
    assign halted     = r_halted;
    assign pc         = r_pc;
    assign dbg_data   = r_rf[dbg_idx];
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: bench-side ROM and ALU, hand-computed expectations.
module tb_cpu_sequencer;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                           ST_EXEC = 3'd3, ST_HALT = 3'd4;

    logic        clk, rst, start, start2;
    int          checks, errors;

    // Instance with the default 8-bit PC.
    logic [7:0]  imem_addr, alu_a, alu_b, alu_result, pc, dbg_data;
    logic        imem_rd_en, alu_carry, rf_we, carry_flag, busy, halted;
    logic [15:0] imem_data;
    logic [2:0]  alu_sel, dbg_state;
    logic [1:0]  rf_widx, dbg_idx;
    logic [15:0] rom [256];

    // Instance with a 2-bit PC for wrap-around.
    logic [1:0]  imem_addr2, pc2, rf_widx2, dbg_idx2;
    logic [7:0]  alu_a2, alu_b2, alu_result2, dbg_data2;
    logic        imem_rd_en2, alu_carry2, rf_we2, carry_flag2, busy2, halted2;
    logic [15:0] imem_data2;
    logic [2:0]  alu_sel2, dbg_state2;

    cpu_sequencer #(.ADDR_W(8), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .start(start), .imem_addr(imem_addr), .imem_rd_en(imem_rd_en),
        .imem_data(imem_data), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_carry(alu_carry), .rf_we(rf_we), .rf_widx(rf_widx),
        .carry_flag(carry_flag), .busy(busy), .halted(halted), .pc(pc),
        .dbg_idx(dbg_idx), .dbg_data(dbg_data), .dbg_state(dbg_state)
    );

    cpu_sequencer #(.ADDR_W(2), .RESET_PC(0)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .imem_addr(imem_addr2), .imem_rd_en(imem_rd_en2),
        .imem_data(imem_data2), .alu_a(alu_a2), .alu_b(alu_b2), .alu_sel(alu_sel2),
        .alu_result(alu_result2), .alu_carry(alu_carry2), .rf_we(rf_we2), .rf_widx(rf_widx2),
        .carry_flag(carry_flag2), .busy(busy2), .halted(halted2), .pc(pc2),
        .dbg_idx(dbg_idx2), .dbg_data(dbg_data2), .dbg_state(dbg_state2)
    );

    // ALU reference: 0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor, 7 cmp-equal.
    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] sel);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (sel)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {a < b, 8'(a - b)};
            3'd2:    return {|p[15:8], p[7:0]};
            3'd3:    return (b == 8'd0) ? 9'h100 : {1'b0, 8'(a / b)};
            3'd4:    return {1'b0, a & b};
            3'd5:    return {1'b0, a | b};
            3'd6:    return {1'b0, a ^ b};
            default: return {8'b0, a == b};
        endcase
    endfunction

    always_comb {alu_carry, alu_result}   = alu_f(alu_a, alu_b, alu_sel);
    always_comb {alu_carry2, alu_result2} = alu_f(alu_a2, alu_b2, alu_sel2);

    // Synchronous ROMs: data appears the cycle after the read strobe.
    always @(posedge clk) if (imem_rd_en) imem_data <= rom[imem_addr];
    always @(posedge clk) if (imem_rd_en2) imem_data2 <= 16'h0200;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reg_chk(input string tag, input logic [1:0] idx, input logic [7:0] exp);
        dbg_idx = idx;
        #1;
        chk(tag, 16'(dbg_data), 16'(exp));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        cyc();
        rst = 1'b1;
    endtask

    task automatic run_prog(input int max_cycles);
        int n;
        start = 1'b1;
        cyc();
        start = 1'b0;
        n = 0;
        while (!halted && n < max_cycles) begin
            cyc();
            n++;
        end
        chk("halt_reached", 16'(halted), 16'd1);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b0; start = 1'b0; start2 = 1'b0; dbg_idx = 2'd0; dbg_idx2 = 2'd0;
        for (int i = 0; i < 256; i++) rom[i] = 16'h8000;

        // 1: reset values, then add-immediate and halt with exact cycle timing.
        rom[0] = 16'h0205; rom[1] = 16'h8000;
        @(negedge clk); @(negedge clk);
        chk("rst_state", 16'(dbg_state), 16'(ST_IDLE));
        chk("rst_pc", 16'(pc), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_halted", 16'(halted), 16'd0);
        chk("rst_alu", {alu_a, alu_b}, 16'd0);
        chk("rst_sel", 16'(alu_sel), 16'd0);
        chk("rst_we_rd", {14'd0, rf_we, imem_rd_en}, 16'd0);
        chk("rst_carry", 16'(carry_flag), 16'd0);
        rst = 1'b1;
        cyc();
        start = 1'b1; cyc(); start = 1'b0;
        chk("t1_fetch_state", 16'(dbg_state), 16'(ST_FETCH));
        chk("t1_fetch_rd_en", 16'(imem_rd_en), 16'd1);
        chk("t1_fetch_busy", 16'(busy), 16'd1);
        cyc();
        chk("t1_decode_state", 16'(dbg_state), 16'(ST_DECODE));
        chk("t1_decode_rd_en", 16'(imem_rd_en), 16'd0);
        cyc();
        chk("t1_exec_we", 16'(rf_we), 16'd1);
        chk("t1_exec_widx", 16'(rf_widx), 16'd0);
        chk("t1_exec_ops", {alu_a, alu_b}, 16'h0005);
        chk("t1_exec_sel", 16'(alu_sel), 16'd0);
        cyc();
        chk("t1_wb_we", 16'(rf_we), 16'd0);
        chk("t1_wb_pc", 16'(pc), 16'd1);
        reg_chk("t1_r0", 2'd0, 8'd5);
        cyc(); cyc();
        chk("t1_halted", 16'(halted), 16'd1);
        chk("t1_halt_busy", 16'(busy), 16'd0);
        chk("t1_halt_pc", 16'(pc), 16'd1);
        chk("t1_halt_state", 16'(dbg_state), 16'(ST_HALT));

        // 2: carry from add overflow, cleared by a logic op on restart from HALT.
        do_reset();
        rom[0] = 16'h02C8; rom[1] = 16'h0264; rom[2] = 16'h8000;
        run_prog(100);
        reg_chk("t2_r0_sum", 2'd0, 8'd44);
        chk("t2_carry_set", 16'(carry_flag), 16'd1);
        chk("t2_pc", 16'(pc), 16'd2);
        rom[0] = 16'h42FF; rom[1] = 16'h8000;
        run_prog(100);
        reg_chk("t2_r0_and", 2'd0, 8'd44);
        chk("t2_carry_clr", 16'(carry_flag), 16'd0);

        // 3: register-register ops, rd==rs, reserved bit ignored.
        do_reset();
        rom[0] = 16'h0607; rom[1] = 16'h0A03; rom[2] = 16'h1402;
        rom[3] = 16'h2401; rom[4] = 16'h0F01; rom[5] = 16'h8000;
        run_prog(100);
        reg_chk("t3_r1_mul", 2'd1, 8'd16);
        reg_chk("t3_r2", 2'd2, 8'd3);
        reg_chk("t3_r3_rsvd", 2'd3, 8'd1);
        chk("t3_carry", 16'(carry_flag), 16'd0);
        chk("t3_pc", 16'(pc), 16'd5);

        // 4: divide by zero, then compare.
        do_reset();
        rom[0] = 16'h0209; rom[1] = 16'h3200; rom[2] = 16'h8000;
        run_prog(100);
        reg_chk("t4_div0_r0", 2'd0, 8'd0);
        chk("t4_div0_carry", 16'(carry_flag), 16'd1);
        rom[0] = 16'h7200; rom[1] = 16'h8000;
        run_prog(100);
        reg_chk("t4_cmp_r0", 2'd0, 8'd1);
        chk("t4_cmp_carry", 16'(carry_flag), 16'd0);

        // 5: 2-bit PC wraps 3 -> 0 and keeps executing.
        start2 = 1'b1; cyc(); start2 = 1'b0;
        repeat (11) cyc();
        chk("t5_pc_3", 16'(pc2), 16'd3);
        chk("t5_exec", 16'(dbg_state2), 16'(ST_EXEC));
        cyc();
        chk("t5_pc_wrap", 16'(pc2), 16'd0);
        chk("t5_busy", {14'd0, busy2, halted2}, 16'b10);
        repeat (3) cyc();
        chk("t5_pc_after", 16'(pc2), 16'd1);
        dbg_idx2 = 2'd0; #1;
        chk("t5_r0", 16'(dbg_data2), 16'd0);

        // 6: reset in EXEC aborts writeback; start while busy is ignored.
        do_reset();
        rom[0] = 16'h0205; rom[1] = 16'h8000;
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc();
        chk("t6_in_exec", 16'(rf_we), 16'd1);
        rst = 1'b0;
        #1;
        chk("t6_rst_state", 16'(dbg_state), 16'(ST_IDLE));
        chk("t6_rst_we", {14'd0, rf_we, imem_rd_en}, 16'd0);
        chk("t6_rst_busy", 16'(busy), 16'd0);
        chk("t6_rst_alu", {alu_a, alu_b}, 16'd0);
        chk("t6_rst_pc", 16'(pc), 16'd0);
        cyc();
        rst = 1'b1;
        reg_chk("t6_no_wb", 2'd0, 8'd0);
        chk("t6_carry", 16'(carry_flag), 16'd0);
        start = 1'b1;
        cyc();
        cyc();
        chk("t6_busy_decode", 16'(dbg_state), 16'(ST_DECODE));
        cyc();
        chk("t6_busy_exec", 16'(dbg_state), 16'(ST_EXEC));
        cyc();
        start = 1'b0;
        chk("t6_pc_no_restart", 16'(pc), 16'd1);
        reg_chk("t6_r0", 2'd0, 8'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
